// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port data-memory arbiter and access sequencer (grant, access, response).
// Define DM_ARB_ROUND_ROBIN_EN for round-robin contention; default is fixed priority to port 0.
module dm_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [1:0]    size0,
    input  logic [1:0]    size1,
    input  logic          sext0,
    input  logic          sext1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          err0,
    output logic          err1,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, state_n;
    logic          owner, we_r, sext_r, err_r, mis, acc, can_grant, pick0, rv0, rv1;
    logic [13:0]   addr_r;
    logic [1:0]    size_r;
    logic [DW-1:0] wdata_r, rdata_r, load_v;
    logic [3:0]    be;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic          unused_addr;
    assign unused_addr = ^{addr0[AW-1:14], addr1[AW-1:14]};
`ifdef DM_ARB_ROUND_ROBIN_EN
    logic last;
    always_ff @(posedge clk) begin
        if (reset)
            last <= 1'b1;
        else if (gnt0 || gnt1)
            last <= gnt1;
    end
    assign pick0 = last;
`else
    assign pick0 = 1'b1;
`endif
    assign can_grant = !reset && (state == IDLE || state == RESP);
    assign gnt0 = can_grant && req0 && (!req1 || pick0);
    assign gnt1 = can_grant && req1 && !(req0 && pick0);
    always_comb begin
        state_n = IDLE;
        if (state == ACCESS)
            state_n = RESP;
        else if (gnt0 || gnt1)
            state_n = ACCESS;
    end
    // size 3 decodes as word via size_r[1]
    always_comb begin
        be     = size_r[1] ? 4'b1111 : size_r[0] ? (addr_r[1] ? 4'b1100 : 4'b0011) : 4'b0001 << addr_r[1:0];
        mis    = size_r[1] ? |addr_r[1:0] : size_r[0] & addr_r[0];
        lane_b = mem_rdata[8*addr_r[1:0] +: 8];
        lane_h = addr_r[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_v = size_r[1] ? mem_rdata :
                 size_r[0] ? {{(DW-16){sext_r & lane_h[15]}}, lane_h} :
                             {{(DW-8){sext_r & lane_b[7]}}, lane_b};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            owner   <= 1'b0;
            we_r    <= 1'b0;
            addr_r  <= '0;
            size_r  <= '0;
            sext_r  <= 1'b0;
            wdata_r <= '0;
            rdata_r <= '0;
            err_r   <= 1'b0;
        end else begin
            state <= state_n;
            if (gnt0 || gnt1) begin
                owner   <= gnt1;
                we_r    <= gnt1 ? we1 : we0;
                addr_r  <= gnt1 ? addr1[13:0] : addr0[13:0];
                size_r  <= gnt1 ? size1 : size0;
                sext_r  <= gnt1 ? sext1 : sext0;
                wdata_r <= gnt1 ? wdata1 : wdata0;
            end
            if (state == ACCESS) begin
                rdata_r <= (we_r || mis) ? '0 : load_v;
                err_r   <= mis;
            end
        end
    end
    assign acc       = state == ACCESS && !reset;
    assign mem_we    = acc && we_r && !mis;
    assign mem_be    = (acc && !mis) ? be : 4'b0000;
    assign mem_addr  = acc ? {{(AW-14){1'b0}}, addr_r[13:2], 2'b00} : '0;
    assign mem_wdata = acc ? wdata_r : '0;
    assign rv0       = state == RESP && !reset && !owner;
    assign rv1       = state == RESP && !reset && owner;
    assign rvalid0   = rv0;
    assign rvalid1   = rv1;
    assign rdata0    = rv0 ? rdata_r : '0;
    assign rdata1    = rv1 ? rdata_r : '0;
    assign err0      = rv0 && err_r;
    assign err1      = rv1 && err_r;
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed scoreboard bench for dm_arbiter with a behavioural word memory.
module tb_dm_arbiter;
    logic        clk, reset, req0, req1, we0, we1, sext0, sext1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [1:0]  size0, size1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_we;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic [31:0] mem [0:4095];
    logic [31:0] ref_mem [0:4095];
    typedef struct {int p; logic [31:0] d; logic e;} exp_t;
    exp_t q[$];
    exp_t e;
    int checks = 0, passed = 0;

    dm_arbiter dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .size0(size0), .size1(size1),
        .sext0(sext0), .sext1(sext1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // memory aligns right-justified store data to the lowest enabled lane
    assign mem_rdata = mem[mem_addr[13:2]];
    always @(posedge clk) begin
        if (mem_we) begin
            logic [31:0] sh;
            sh = mem_wdata << (mem_be[0] ? 0 : mem_be[1] ? 8 : mem_be[2] ? 16 : 24);
            for (int i = 0; i < 4; i++)
                if (mem_be[i]) mem[mem_addr[13:2]][8*i +: 8] <= sh[8*i +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] a,
                                             input logic [1:0] sz, input logic sx);
        logic [31:0] s;
        s = w >> (8 * a);
        if (sz == 2'd0) return sx ? {{24{s[7]}}, s[7:0]} : {24'h0, s[7:0]};
        if (sz == 2'd1) return sx ? {{16{s[15]}}, s[15:0]} : {16'h0, s[15:0]};
        return w;
    endfunction

    task automatic drive(input int p, input logic v, input logic we, input logic [31:0] a,
                         input logic [1:0] sz, input logic sx, input logic [31:0] wd);
        if (p == 0) begin req0 = v; we0 = we; addr0 = a; size0 = sz; sext0 = sx; wdata0 = wd; end
        else begin req1 = v; we1 = we; addr1 = a; size1 = sz; sext1 = sx; wdata1 = wd; end
    endtask

    task automatic expect_resp(input int p, input logic we, input logic [31:0] a,
                               input logic [1:0] sz, input logic sx, input logic [31:0] wd);
        exp_t x;
        logic mis;
        logic [3:0] be;
        logic [31:0] sh;
        mis = (sz == 2'd1 && a[0]) || (sz[1] && a[1:0] != 2'd0);
        be = sz[1] ? 4'hF : sz[0] ? (a[1] ? 4'hC : 4'h3) : 4'h1 << a[1:0];
        x.p = p;
        x.e = mis;
        x.d = (we || mis) ? 32'h0 : exp_load(ref_mem[a[13:2]], a[1:0], sz, sx);
        q.push_back(x);
        if (we && !mis) begin
            sh = wd << (8 * a[1:0]);
            for (int i = 0; i < 4; i++)
                if (be[i]) ref_mem[a[13:2]][8*i +: 8] = sh[8*i +: 8];
        end
    endtask

    task automatic xact(input int p, input logic we, input logic [31:0] a,
                        input logic [1:0] sz, input logic sx, input logic [31:0] wd);
        int n;
        logic mis;
        logic [3:0] be;
        mis = (sz == 2'd1 && a[0]) || (sz[1] && a[1:0] != 2'd0);
        be = sz[1] ? 4'hF : sz[0] ? (a[1] ? 4'hC : 4'h3) : 4'h1 << a[1:0];
        @(negedge clk);
        drive(p, 1'b1, we, a, sz, sx, wd);
        #1;
        n = 0;
        while (!(p == 1 ? gnt1 : gnt0) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("grant_timeout", 32'(n < 20), 32'd1);
        expect_resp(p, we, a, sz, sx, wd);
        @(posedge clk);
        #1;
        drive(p, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
        chk("acc_mem_we", 32'(mem_we), 32'(we && !mis));
        chk("acc_mem_be", 32'(mem_be), mis ? 32'h0 : 32'(be));
        chk("acc_mem_addr", mem_addr, {18'h0, a[13:2], 2'b00});
        if (we) chk("acc_mem_wdata", mem_wdata, wd);
        @(posedge clk);
        #1;
        chk("rvalid_at_n2", 32'(p == 1 ? rvalid1 : rvalid0), 32'd1);
    endtask

    always @(negedge clk) begin
        if (!reset && (rvalid0 || rvalid1)) begin
            if (q.size() == 0) chk("unexpected_rvalid", {30'h0, rvalid1, rvalid0}, 32'h0);
            else begin
                e = q.pop_front();
                chk("resp_port", {30'h0, rvalid1, rvalid0}, e.p == 1 ? 32'd2 : 32'd1);
                chk("resp_rdata", e.p == 1 ? rdata1 : rdata0, e.d);
                chk("resp_err", 32'(e.p == 1 ? err1 : err0), 32'(e.e));
                chk("other_rdata", e.p == 1 ? rdata0 : rdata1, 32'h0);
            end
        end
    end

    initial begin
        logic [3:0] ord;
        int ng, n;
        for (int i = 0; i < 4096; i++) begin mem[i] = 32'h0; ref_mem[i] = 32'h0; end
        reset = 1;
        drive(0, 1'b1, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_no_gnt", {30'h0, gnt1, gnt0}, 32'h0);
        chk("reset_ctrl", {24'h0, rvalid0, rvalid1, err0, err1, mem_we, mem_be[2:0]}, 32'h0);
        chk("reset_data", rdata0 | rdata1 | mem_addr | mem_wdata | {28'h0, mem_be}, 32'h0);
        drive(0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
        @(negedge clk);
        reset = 0;

        xact(0, 1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF);
        xact(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
        xact(1, 1'b1, 32'h13, 2'd0, 1'b0, 32'h80);
        xact(1, 1'b0, 32'h13, 2'd0, 1'b1, 32'h0);
        xact(1, 1'b0, 32'h13, 2'd0, 1'b0, 32'h0);
        xact(0, 1'b1, 32'h21, 2'd1, 1'b0, 32'hABCD);
        chk("misaligned_mem_unchanged", mem[8], 32'h0);
        xact(0, 1'b0, 32'h16, 2'd3, 1'b0, 32'h0);
        xact(1, 1'b0, 32'h20, 2'd2, 1'b0, 32'h0);

`ifdef DM_ARB_ROUND_ROBIN_EN
        ord = 4'b1010;
`else
        ord = 4'b0000;
`endif
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h12, 2'd1, 1'b0, 32'h0);
        ng = 0;
        n = 0;
        while (ng < 4 && n < 40) begin
            #1;
            if (gnt0 || gnt1) begin
                chk("contention_order", 32'(gnt1), 32'(ord[ng]));
                if (gnt1) expect_resp(1, 1'b0, 32'h12, 2'd1, 1'b0, 32'h0);
                else expect_resp(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
                ng++;
            end
            @(negedge clk);
            n++;
        end
        chk("contention_grants", 32'(ng), 32'd4);
        drive(0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain", 32'(q.size()), 32'd0);

        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h40, 2'd2, 1'b0, 32'h12345678);
        #1;
        chk("rst_store_gnt", 32'(gnt0), 32'd1);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
        reset = 1;
        #1;
        chk("rst_access_we", {27'h0, mem_we, mem_be}, 32'h0);
        @(posedge clk);
        #1;
        reset = 0;
        #1;
        chk("post_rst_ctrl", {24'h0, gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_we, 1'b0}, 32'h0);
        chk("post_rst_data", rdata0 | rdata1 | mem_addr | mem_wdata | {28'h0, mem_be}, 32'h0);
        repeat (3) @(negedge clk);
        chk("rst_no_write", mem[16], 32'h0);
        xact(0, 1'b0, 32'h40, 2'd2, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        chk("final_queue", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-requester arbiter and access sequencer for the word-organised data memory. It shares the memory between the CPU data port (port 0) and a DMA/debug port (port 1). For each accepted request it generates the word address and 4-bit byte-lane enable, and performs the access. It then returns lane-extracted, sign- or zero-extended read data with a one-cycle valid pulse.

## Interface
- AW, 32, requester address width; memory word index is addr[13:2].
- DW, 32, data width; only 32 supported.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- req0 / req1  in  1  request from port 0 / port 1.
- we0 / we1  in  1  1 = store, 0 = load.
- addr0 / addr1  in  AW  byte address.
- size0 / size1  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- sext0 / sext1  in  1  sign-extend load data; 0 = zero-extend.
- wdata0 / wdata1  in  DW  store data, right-aligned (byte in [7:0], half in [15:0]).
- gnt0 / gnt1  out  1  combinational; request accepted at this rising edge.
- rvalid0 / rvalid1  out  1  one-cycle completion pulse.
- rdata0 / rdata1  out  DW  load result; valid only with rvalid.
- err0 / err1  out  1  misaligned access; valid only with rvalid.
- mem_addr  out  AW  {18'b0, word index, 2'b00}.
- mem_be  out  4  byte-lane enable to memory.
- mem_we  out  1  memory write enable.
- mem_wdata  out  DW  requester wdata, passed unshifted; memory selects lanes from mem_be.
- mem_rdata  in  DW  combinational word read of mem_addr.

## Operation
- FSM states are IDLE, ACCESS, RESP.
  - IDLE and RESP may grant. A grant latches owner, we, addr, size, sext, wdata and moves to ACCESS; no grant moves to IDLE.
  - ACCESS always moves to RESP.
- Arbitration applies only when both ports request in a granting state; otherwise the single requester is granted.
- Byte-enable generation:
  - byte: 4'b0001 << addr[1:0].
  - half: addr[1] ? 4'b1100 : 4'b0011.
  - word: 4'b1111.
- Misalignment:
  - Half with addr[0]=1, or word with addr[1:0]≠0, is misaligned.
  - In ACCESS a misaligned request drives mem_be=0 and mem_we=0, and err is set.
- ACCESS cycle outputs:
  - mem_we = latched we and not misaligned.
  - mem_addr, mem_be, mem_wdata are driven from the latched request.
  - mem_rdata lane is captured at the end of ACCESS.
- Load lane extraction:
  - byte = mem_rdata[8*addr[1:0] +: 8].
  - half = addr[1] ? [31:16] : [15:0].
  - Result is extended to 32 bits per sext.
  - Stores and errors return rdata = 0.
- RESP cycle:
  - rvalid and err go only to the latched owner; the other port's rvalid, err and rdata are 0.
- Outside ACCESS: mem_we = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0.

## Timing
- Request sampled in cycle N (gnt high), memory access in N+1, rvalid in N+2.
- Back-to-back throughput is one access per 2 cycles, because a grant in RESP overlaps the response.
- A requester must hold req and its request fields stable until gnt; it may drop req in the cycle after gnt.
- Reset values:
  - state = IDLE, last-served pointer = 1 (port 0 wins first contention).
  - All outputs 0, including gnt.
- Reset asserted during ACCESS: reset dominates, so mem_we = 0 that cycle, no write occurs, the pending response is dropped, and no rvalid is issued.
- Reset asserted during RESP: rvalid is suppressed.
- No grant is given while reset is high.

## Configuration
- DM_ARB_ROUND_ROBIN_EN defined:
  - On contention the port not served last wins.
  - The pointer updates on every grant.
- DM_ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority; port 0 always wins contention.
  - The pointer register is not implemented.

## Test plan
- Port 0 word store: addr 0x10, data 0xDEADBEEF, then load of 0x10 → write in ACCESS with mem_be=4'b1111, mem_addr=0x10; load rvalid0 at N+2 with rdata0=0xDEADBEEF.
- Byte store, signed load: port 1 stores byte 0x80 at addr 0x13, then loads 0x13 with sext=1 → mem_be=4'b1000 on the store; load returns rdata1=0xFFFFFF80. The same load with sext=0 returns 0x00000080.
- Misaligned half store: addr 0x21 → mem_we and mem_be stay 0, memory is unchanged, rvalid0 and err0 pulse with rdata0=0.
- Contention, both req held for 4 grants:
  - Round-robin build: grants alternate 0,1,0,1.
  - Fixed-priority build: grants are 0,0,0,0.
- Reset asserted in the ACCESS cycle of a word store to 0x40 → no write occurs (a later load returns the prior value), no rvalid, and all outputs are 0 the next cycle.
